// File: rtl/temp_ram_reader_if.sv
// Sample-RAM read port plus the averaged result bus of the temperature reader.
// master = the reader block; slave = the RAM/consumer side.
`timescale 1ns/1ps
interface temp_ram_reader_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_q;
  logic              busy;
  logic              avg_valid;
  logic [DATA_W-1:0] avg_data;
  logic [7:0]        led;

  modport master (
    input  start, ram_q,
    output ram_address, ram_rden, busy, avg_valid, avg_data, led
  );

  modport slave (
    output start, ram_q,
    input  ram_address, ram_rden, busy, avg_valid, avg_data, led
  );
endinterface

// File: rtl/temp_ram_reader.sv
// Scans all 2^ADDR_W sample-RAM entries on start/periodic tick and publishes their mean.
// Result N+RD_LAT+1 cycles after trigger; no backpressure, triggers while busy are dropped.
`timescale 1ns/1ps
module temp_ram_reader #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 2,
  parameter int PERIOD = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  temp_ram_reader_if.master   bus
);
  localparam int N     = 1 << ADDR_W;
  localparam int ACC_W = DATA_W + ADDR_W;
  localparam int PLIM  = (PERIOD > 0) ? PERIOD - 1 : 0;
  localparam int PCW   = (PLIM > 0) ? $clog2(PLIM + 1) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic              tick;
  logic [RD_LAT-1:0] flag_pipe;
  logic              ret_vld;
  logic              last_ret;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0] avg_next;
  logic [ADDR_W-1:0] rcv_cnt;

  logic [ADDR_W-1:0] ram_address_q;
  logic              ram_rden_q;
  logic              busy_q;
  logic              avg_valid_q;
  logic [DATA_W-1:0] avg_data_q;
  logic [7:0]        led_q;

  // Free-running period counter; PERIOD of 0 removes the auto-trigger entirely.
  generate
    if (PERIOD > 0) begin : g_tick
      logic [PCW-1:0] per_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          per_cnt <= '0;
        else if (per_cnt == PCW'(PLIM))
          per_cnt <= '0;
        else
          per_cnt <= per_cnt + 1'b1;
      end

      assign tick = (per_cnt == PCW'(PLIM));
    end else begin : g_no_tick
      assign tick = 1'b0;
    end
  endgenerate

  // Each issued read pushes a flag; the flag leaves the pipe when its data is on ram_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flag_pipe <= '0;
    else
      flag_pipe <= (flag_pipe << 1) | RD_LAT'(ram_rden_q);
  end

  assign ret_vld  = flag_pipe[RD_LAT-1];
  assign last_ret = ret_vld && (rcv_cnt == ADDR_W'(N - 1));
  assign acc_next = ret_vld ? (acc + ACC_W'(bus.ram_q)) : acc;
  assign avg_next = acc_next[ACC_W-1:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ram_address_q <= '0;
      ram_rden_q    <= 1'b0;
      busy_q        <= 1'b0;
      avg_valid_q   <= 1'b0;
      avg_data_q    <= '0;
      led_q         <= '0;
      acc           <= '0;
      rcv_cnt       <= '0;
    end else begin
      avg_valid_q <= 1'b0;
      acc         <= acc_next;
      if (ret_vld)
        rcv_cnt <= rcv_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (bus.start || tick) begin
            state         <= READ;
            ram_rden_q    <= 1'b1;
            ram_address_q <= '0;
            busy_q        <= 1'b1;
            acc           <= '0;
            rcv_cnt       <= '0;
          end
        end
        READ: begin
          if (ram_address_q == ADDR_W'(N - 1)) begin
            ram_rden_q    <= 1'b0;
            ram_address_q <= '0;
            state         <= DRAIN;
          end else begin
            ram_address_q <= ram_address_q + 1'b1;
          end
        end
        DRAIN: begin
          // The final sample is folded in on the same edge that publishes the mean.
          if (last_ret) begin
            state       <= DONE;
            avg_valid_q <= 1'b1;
            avg_data_q  <= avg_next;
            led_q       <= avg_next[DATA_W-1 -: 8];
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_address = ram_address_q;
  assign bus.ram_rden    = ram_rden_q;
  assign bus.busy        = busy_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.avg_data    = avg_data_q;
  assign bus.led         = led_q;
endmodule
